axi3_wid_tagger: RTL and testbench
==================================

Name: axi3_wid_tagger

Overview:
- Sits directly downstream of the AXI passthrough. That block drives WID to zero, but AXI3 slaves (Zynq HP/ACP ports) require WID on every write beat.
- This block records each accepted AWID in order in an ID FIFO and tags every W beat of the corresponding burst with that ID.
- AW payload passes through combinationally, gated only by FIFO space.
- The W channel is stalled until the matching AW has been accepted.

Parameters:
- C_AXI_ID_WIDTH, 1, width of AWID/WID.
- C_AXI_ADDR_WIDTH, 32, width of AWADDR.
- C_AXI_DATA_MAX_WIDTH, 32, WDATA width; WSTRB width is C_AXI_DATA_MAX_WIDTH/8.
- C_ID_FIFO_DEPTH, 8, outstanding write-burst IDs; power of 2, minimum 2.

Ports:
- INTERCONNECT_ACLK  in  1  single clock for all logic.
- INTERCONNECT_ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWID  in  C_AXI_ID_WIDTH  upstream write ID.
- S_AXI_AWADDR  in  C_AXI_ADDR_WIDTH  write address.
- S_AXI_AWLEN  in  8  burst length-1; upstream guarantees <=15.
- S_AXI_AWSIZE  in  3 / S_AXI_AWBURST  in  2  burst size/type.
- S_AXI_AWVALID  in  1 / S_AXI_AWREADY  out  1  AW handshake.
- S_AXI_WDATA  in  C_AXI_DATA_MAX_WIDTH / S_AXI_WSTRB  in  C_AXI_DATA_MAX_WIDTH/8  write beat.
- S_AXI_WLAST  in  1 / S_AXI_WVALID  in  1 / S_AXI_WREADY  out  1  W handshake.
- M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWSIZE, M_AXI_AWBURST  out  same widths as S_AXI_*  copies of the upstream AW fields.
- M_AXI_AWLEN  out  4  S_AXI_AWLEN[3:0].
- M_AXI_AWVALID  out  1 / M_AXI_AWREADY  in  1  downstream AW handshake.
- M_AXI_WID  out  C_AXI_ID_WIDTH  FIFO head ID.
- M_AXI_WDATA, M_AXI_WSTRB  out  copies of the upstream W data/strobe.
- M_AXI_WLAST  out  1 / M_AXI_WVALID  out  1 / M_AXI_WREADY  in  1  downstream W handshake.
- WLAST_ERR  out  1  sticky protocol error flag (see Optional Feature).
- AWLOCK/CACHE/PROT/QOS, B and AR/R channels are routed around this block.

Behaviour:
- State: ID FIFO (circular buffer), write pointer wp, read pointer rp, occupancy count cnt of width clog2(depth)+1. full = (cnt==depth); empty = (cnt==0).
- Reset (INTERCONNECT_ARESET high at a clock edge): wp=rp=cnt=0, WLAST_ERR=0.
- While reset is high: S_AXI_AWREADY, M_AXI_AWVALID, S_AXI_WREADY and M_AXI_WVALID are forced to 0.
- Reset mid-burst discards all queued IDs; a partially transferred W burst is abandoned.
- AW channel (zero latency):
  - M_AXI_AWVALID = S_AXI_AWVALID & ~full.
  - S_AXI_AWREADY = M_AXI_AWREADY & ~full.
  - Push S_AXI_AWID into FIFO[wp] on M_AXI_AWVALID & M_AXI_AWREADY.
- W channel:
  - M_AXI_WVALID = S_AXI_WVALID & ~empty.
  - S_AXI_WREADY = M_AXI_WREADY & ~empty.
  - M_AXI_WID = FIFO[rp].
  - Pop on a W handshake with WLAST=1.
- No AW-to-W bypass: the W beat of a burst whose AW was accepted in cycle N is presented no earlier than cycle N+1.
- W data arriving before its AW stalls; it is never dropped or mis-tagged.
- Push and pop in the same cycle: cnt is unchanged and both pointers advance. This is legal when full (pop frees the entry, but AWREADY is evaluated on pre-pop full and stays low that cycle).
- Pointers wrap modulo C_ID_FIFO_DEPTH.
- VALID handling follows AXI: once asserted with a stall, the output holds because upstream holds.
- Without the optional feature, M_AXI_WLAST = S_AXI_WLAST and WLAST_ERR is tied 0.

Optional Feature:
Macro: AXI3_WID_TAGGER_LEN_CHECK_EN.
- With the macro defined:
  - The FIFO also stores AWLEN[3:0].
  - A 4-bit beat counter counts W handshakes; it is cleared on pop and on reset.
  - M_AXI_WLAST is driven from the counter (counter == stored len), and the pop uses this generated WLAST.
  - WLAST_ERR is set and held until reset when either:
    - S_AXI_WLAST differs from the generated WLAST on any W handshake; or
    - S_AXI_AWLEN[7:4] != 0 on an AW handshake.
- Without the macro: no length storage or counter, and WLAST_ERR = 0.

Test Plan:
- Reset, then AWID=3 AWLEN=0 in cycle 1; single W beat already valid. Required: W beat out in cycle 2 with WID=3, WLAST=1; FIFO empty afterwards.
- W valid 4 cycles before AW (ID=1, len=3). Required: WVALID out stays 0 until the cycle after AW handshake, then 4 beats with WID=1.
- Push 8 AWs (IDs 0..7) with W held off. Required: the 9th AW sees AWREADY=0. Then W beats drain in order, WID 0,1,...,7; AWREADY returns the cycle after the first pop.
- FIFO full, and in the same cycle a WLAST pop plus a pending AW. Required: AW accepted the next cycle, cnt returns to 8, ordering preserved across pointer wrap.
- Assert reset mid-burst (2 of 4 beats sent). Required: all VALID/READY outputs 0, cnt=0; a new AW ID=5 is then tagged correctly.
- With LEN_CHECK_EN, AWLEN=3 and S_AXI_WLAST asserted on beat 2. Required: M_AXI_WLAST asserts on beat 4 only; WLAST_ERR=1 from the cycle after beat 2 until reset.

Source files
------------

// File: rtl/axi3_wid_tagger_if.sv
// AXI3 write-address / write-data bundle around the WID tagger.
// slave = tagger side, master = upstream source plus downstream sink.
interface axi3_wid_tagger_if #(
   parameter int C_AXI_ID_WIDTH       = 1,
   parameter int C_AXI_ADDR_WIDTH     = 32,
   parameter int C_AXI_DATA_MAX_WIDTH = 32
);
   logic [C_AXI_ID_WIDTH-1:0]         S_AXI_AWID;
   logic [C_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR;
   logic [7:0]                        S_AXI_AWLEN;
   logic [2:0]                        S_AXI_AWSIZE;
   logic [1:0]                        S_AXI_AWBURST;
   logic                              S_AXI_AWVALID;
   logic                              S_AXI_AWREADY;
   logic [C_AXI_DATA_MAX_WIDTH-1:0]   S_AXI_WDATA;
   logic [C_AXI_DATA_MAX_WIDTH/8-1:0] S_AXI_WSTRB;
   logic                              S_AXI_WLAST;
   logic                              S_AXI_WVALID;
   logic                              S_AXI_WREADY;

   logic [C_AXI_ID_WIDTH-1:0]         M_AXI_AWID;
   logic [C_AXI_ADDR_WIDTH-1:0]       M_AXI_AWADDR;
   logic [3:0]                        M_AXI_AWLEN;
   logic [2:0]                        M_AXI_AWSIZE;
   logic [1:0]                        M_AXI_AWBURST;
   logic                              M_AXI_AWVALID;
   logic                              M_AXI_AWREADY;
   logic [C_AXI_ID_WIDTH-1:0]         M_AXI_WID;
   logic [C_AXI_DATA_MAX_WIDTH-1:0]   M_AXI_WDATA;
   logic [C_AXI_DATA_MAX_WIDTH/8-1:0] M_AXI_WSTRB;
   logic                              M_AXI_WLAST;
   logic                              M_AXI_WVALID;
   logic                              M_AXI_WREADY;

   modport slave (
      input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
      input  S_AXI_AWBURST, S_AXI_AWVALID,
      output S_AXI_AWREADY,
      input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      output S_AXI_WREADY,
      output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
      output M_AXI_AWBURST, M_AXI_AWVALID,
      input  M_AXI_AWREADY,
      output M_AXI_WID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST,
      output M_AXI_WVALID,
      input  M_AXI_WREADY
   );

   modport master (
      output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
      output S_AXI_AWBURST, S_AXI_AWVALID,
      input  S_AXI_AWREADY,
      output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
      input  S_AXI_WREADY,
      input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE,
      input  M_AXI_AWBURST, M_AXI_AWVALID,
      output M_AXI_AWREADY,
      input  M_AXI_WID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST,
      input  M_AXI_WVALID,
      output M_AXI_WREADY
   );
endinterface

// File: rtl/axi3_wid_tagger.sv
// Tags AXI3 W beats with the AWID of their burst via an in-order ID FIFO.
// Optional macro AXI3_WID_TAGGER_LEN_CHECK_EN: generate WLAST from AWLEN and flag mismatches.
module axi3_wid_tagger #(
   parameter int C_AXI_ID_WIDTH       = 1,
   parameter int C_AXI_ADDR_WIDTH     = 32,
   parameter int C_AXI_DATA_MAX_WIDTH = 32,
   parameter int C_ID_FIFO_DEPTH      = 8
) (
   input  logic             INTERCONNECT_ACLK,
   input  logic             INTERCONNECT_ARESET,
   axi3_wid_tagger_if.slave bus,
   output logic             WLAST_ERR
);

   localparam int PW = (C_ID_FIFO_DEPTH > 1) ? $clog2(C_ID_FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(C_ID_FIFO_DEPTH);

   logic clk;
   logic rst;
   assign clk = INTERCONNECT_ACLK;
   assign rst = INTERCONNECT_ARESET;

   logic [C_AXI_ID_WIDTH-1:0] id_mem_q [C_ID_FIFO_DEPTH];
   logic [PW-1:0]             wp_q, wp_d;
   logic [PW-1:0]             rp_q, rp_d;
   logic [CW-1:0]             cnt_q, cnt_d;

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic w_hs;
   logic wlast_eff;

   assign full  = (cnt_q == DEPTH_C);
   assign empty = (cnt_q == '0);

   // AW payload is a straight copy; only the handshake is gated
   assign bus.M_AXI_AWID    = bus.S_AXI_AWID;
   assign bus.M_AXI_AWADDR  = bus.S_AXI_AWADDR;
   assign bus.M_AXI_AWLEN   = bus.S_AXI_AWLEN[3:0];
   assign bus.M_AXI_AWSIZE  = bus.S_AXI_AWSIZE;
   assign bus.M_AXI_AWBURST = bus.S_AXI_AWBURST;
   assign bus.M_AXI_AWVALID = ~rst & bus.S_AXI_AWVALID & ~full;
   assign bus.S_AXI_AWREADY = ~rst & bus.M_AXI_AWREADY & ~full;

   // W beats wait on a queued ID; empty is registered, so no AW-to-W bypass
   assign bus.M_AXI_WID     = id_mem_q[rp_q];
   assign bus.M_AXI_WDATA   = bus.S_AXI_WDATA;
   assign bus.M_AXI_WSTRB   = bus.S_AXI_WSTRB;
   assign bus.M_AXI_WLAST   = wlast_eff;
   assign bus.M_AXI_WVALID  = ~rst & bus.S_AXI_WVALID & ~empty;
   assign bus.S_AXI_WREADY  = ~rst & bus.M_AXI_WREADY & ~empty;

   assign push = bus.M_AXI_AWVALID & bus.M_AXI_AWREADY;
   assign w_hs = bus.M_AXI_WVALID & bus.M_AXI_WREADY;
   assign pop  = w_hs & wlast_eff;

`ifdef AXI3_WID_TAGGER_LEN_CHECK_EN
   logic [3:0] len_mem_q [C_ID_FIFO_DEPTH];
   logic [3:0] beat_q, beat_d;
   logic       err_q, err_d;
   logic       gen_last;

   assign gen_last  = (beat_q == len_mem_q[rp_q]);
   assign wlast_eff = gen_last;
   assign WLAST_ERR = err_q;

   // Beat counter restarts per burst; error is sticky until reset
   always_comb begin
      beat_d = beat_q;
      err_d  = err_q;
      if (pop) begin
         beat_d = '0;
      end else if (w_hs) begin
         beat_d = beat_q + 4'd1;
      end
      if (w_hs && (bus.S_AXI_WLAST != gen_last)) begin
         err_d = 1'b1;
      end
      if (push && (bus.S_AXI_AWLEN[7:4] != 4'd0)) begin
         err_d = 1'b1;
      end
   end

   // Length-check state
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         beat_q <= beat_d;
         err_q  <= err_d;
      end
   end

   // Burst length storage alongside the ID
   always_ff @(posedge clk) begin
      if (push) begin
         len_mem_q[wp_q] <= bus.S_AXI_AWLEN[3:0];
      end
   end
`else
   assign wlast_eff = bus.S_AXI_WLAST;
   assign WLAST_ERR = 1'b0;
`endif

   // Pointer and occupancy next-state; push+pop leaves cnt unchanged
   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (push) begin
         wp_d = wp_q + PW'(1);
      end
      if (pop) begin
         rp_d = rp_q + PW'(1);
      end
      if (push && !pop) begin
         cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // FIFO control state; reset drops all queued IDs
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   // ID storage, written at the AW handshake
   always_ff @(posedge clk) begin
      if (push) begin
         id_mem_q[wp_q] <= bus.S_AXI_AWID;
      end
   end

endmodule

// File: tb/tb_axi3_wid_tagger.sv
// Self-checking bench for axi3_wid_tagger.
// Table vectors, directed corner sequences and a randomized burst model.
module tb_axi3_wid_tagger;
   localparam int IDW   = 3;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int NB    = 150;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic wlast_err;
   int   tests = 0;
   int   fails = 0;

   axi3_wid_tagger_if #(
      .C_AXI_ID_WIDTH(IDW),
      .C_AXI_ADDR_WIDTH(AW),
      .C_AXI_DATA_MAX_WIDTH(DW)
   ) bus ();

   axi3_wid_tagger #(
      .C_AXI_ID_WIDTH(IDW),
      .C_AXI_ADDR_WIDTH(AW),
      .C_AXI_DATA_MAX_WIDTH(DW),
      .C_ID_FIFO_DEPTH(DEPTH)
   ) dut (
      .INTERCONNECT_ACLK(clk),
      .INTERCONNECT_ARESET(rst),
      .bus(bus),
      .WLAST_ERR(wlast_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int fill;
      bit awv, mawr, wv, mwr;
      bit e_awv, e_awr, e_wv, e_wr;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic idle();
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_AWID    = '0;
      bus.S_AXI_AWADDR  = '0;
      bus.S_AXI_AWLEN   = '0;
      bus.S_AXI_AWSIZE  = 3'd2;
      bus.S_AXI_AWBURST = 2'd1;
      bus.S_AXI_WVALID  = 1'b0;
      bus.S_AXI_WDATA   = '0;
      bus.S_AXI_WSTRB   = '1;
      bus.S_AXI_WLAST   = 1'b0;
      bus.M_AXI_AWREADY = 1'b1;
      bus.M_AXI_WREADY  = 1'b1;
   endtask

   task automatic chk_outs_zero(input string nm);
      chk({nm, "_awvalid"}, bus.M_AXI_AWVALID, 0);
      chk({nm, "_awready"}, bus.S_AXI_AWREADY, 0);
      chk({nm, "_wvalid"},  bus.M_AXI_WVALID,  0);
      chk({nm, "_wready"},  bus.S_AXI_WREADY,  0);
   endtask

   task automatic apply_reset(input bit do_chk);
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = 1'b1;
      bus.M_AXI_AWREADY = 1'b1;
      bus.M_AXI_WREADY  = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      if (do_chk) chk_outs_zero("reset");
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle();
   endtask

   task automatic push_aw(input int id, input int len);
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_AWID    = IDW'(id);
      bus.S_AXI_AWLEN   = 8'(len);
      bus.S_AXI_AWADDR  = $urandom;
      @(negedge clk);
      chk("push_awready", bus.S_AXI_AWREADY, 1);
      chk("push_awlen", bus.M_AXI_AWLEN, 64'(len & 15));
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0;
   endtask

   task automatic w_beat(input string nm, input int id, input bit last);
      logic [DW-1:0] d;
      d = $urandom;
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_WLAST  = last;
      bus.S_AXI_WDATA  = d;
      @(negedge clk);
      chk({nm, "_wvalid"}, bus.M_AXI_WVALID, 1);
      chk({nm, "_wid"},    bus.M_AXI_WID, 64'(id));
      chk({nm, "_wlast"},  bus.M_AXI_WLAST, 64'(last));
      chk({nm, "_wdata"},  bus.M_AXI_WDATA, 64'(d));
      @(posedge clk); #1;
      bus.S_AXI_WVALID = 1'b0;
      bus.S_AXI_WLAST  = 1'b0;
   endtask

   task automatic chk_empty(input string nm);
      bus.S_AXI_WVALID = 1'b1;
      @(negedge clk);
      chk({nm, "_empty"}, bus.M_AXI_WVALID, 0);
      @(posedge clk); #1;
      bus.S_AXI_WVALID = 1'b0;
   endtask

   vec_t vt [9];
   int   b_id  [NB];
   int   b_len [NB];

   initial begin
      vt[0] = '{0, 1,1,1,1, 1,1,0,0};
      vt[1] = '{0, 1,0,0,1, 1,0,0,0};
      vt[2] = '{0, 0,1,1,0, 0,1,0,0};
      vt[3] = '{1, 1,1,1,1, 1,1,1,1};
      vt[4] = '{1, 0,0,1,0, 0,0,1,0};
      vt[5] = '{1, 0,1,0,1, 0,1,0,1};
      vt[6] = '{8, 1,1,1,1, 0,0,1,1};
      vt[7] = '{8, 1,0,0,0, 0,0,0,0};
      vt[8] = '{8, 0,1,1,1, 0,0,1,1};

      idle();
      apply_reset(1'b1);
      chk("reset_err", wlast_err, 0);

      // Handshake gating at empty / partly filled / full
      for (int v = 0; v < 9; v++) begin
         apply_reset(1'b0);
         for (int f = 0; f < vt[v].fill; f++) push_aw(f, 0);
         bus.S_AXI_AWVALID = vt[v].awv;
         bus.M_AXI_AWREADY = vt[v].mawr;
         bus.S_AXI_WVALID  = vt[v].wv;
         bus.M_AXI_WREADY  = vt[v].mwr;
         bus.S_AXI_WLAST   = 1'b1;
         @(negedge clk);
         chk($sformatf("vec%0d_awvalid", v), bus.M_AXI_AWVALID, 64'(vt[v].e_awv));
         chk($sformatf("vec%0d_awready", v), bus.S_AXI_AWREADY, 64'(vt[v].e_awr));
         chk($sformatf("vec%0d_wvalid", v),  bus.M_AXI_WVALID,  64'(vt[v].e_wv));
         chk($sformatf("vec%0d_wready", v),  bus.S_AXI_WREADY,  64'(vt[v].e_wr));
         @(posedge clk); #1;
         idle();
      end

      // AW ID=3 len 0 with its single W beat already waiting
      apply_reset(1'b0);
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_AWID    = 3'd3;
      bus.S_AXI_WVALID  = 1'b1;
      bus.S_AXI_WLAST   = 1'b1;
      @(negedge clk);
      chk("t1_awvalid", bus.M_AXI_AWVALID, 1);
      chk("t1_nobypass", bus.M_AXI_WVALID, 0);
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0;
      w_beat("t1", 3, 1'b1);
      chk_empty("t1");

      // W valid four cycles ahead of its AW
      bus.S_AXI_WVALID = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) begin
            bus.S_AXI_AWVALID = 1'b1;
            bus.S_AXI_AWID    = 3'd1;
            bus.S_AXI_AWLEN   = 8'd3;
         end
         @(negedge clk);
         chk($sformatf("t2_stall%0d", i), bus.M_AXI_WVALID, 0);
         @(posedge clk); #1;
      end
      bus.S_AXI_AWVALID = 1'b0;
      for (int b = 0; b < 4; b++) w_beat("t2", 1, b == 3);
      chk_empty("t2");

      // Fill to full, pop one with an AW pending, refill across wrap
      apply_reset(1'b0);
      for (int i = 0; i < 8; i++) push_aw(i, 0);
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_AWID    = 3'd5;
      bus.S_AXI_AWLEN   = 8'd0;
      @(negedge clk);
      chk("t3_full_awready", bus.S_AXI_AWREADY, 0);
      chk("t3_full_awvalid", bus.M_AXI_AWVALID, 0);
      @(posedge clk); #1;
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_WLAST  = 1'b1;
      @(negedge clk);
      chk("t3_pop_wid", bus.M_AXI_WID, 0);
      chk("t3_pop_awready", bus.S_AXI_AWREADY, 0);
      @(posedge clk); #1;
      bus.S_AXI_WVALID = 1'b0;
      @(negedge clk);
      chk("t3_after_pop_awready", bus.S_AXI_AWREADY, 1);
      @(posedge clk); #1;
      bus.S_AXI_AWID = 3'd6;
      @(negedge clk);
      chk("t3_refull_awready", bus.S_AXI_AWREADY, 0);
      @(posedge clk); #1;
      bus.S_AXI_AWVALID = 1'b0;
      for (int k = 0; k < 8; k++) w_beat("t3_drain", (k < 7) ? k + 1 : 5, 1'b1);
      chk_empty("t3");

      // Reset in the middle of a four-beat burst
      apply_reset(1'b0);
      push_aw(4, 3);
      w_beat("t5_pre", 4, 1'b0);
      w_beat("t5_pre", 4, 1'b0);
      bus.S_AXI_AWVALID = 1'b1;
      bus.S_AXI_WVALID  = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk_outs_zero("t5_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      idle();
      chk_empty("t5");
      push_aw(5, 0);
      w_beat("t5_post", 5, 1'b1);
      chk_empty("t5_post");

`ifdef AXI3_WID_TAGGER_LEN_CHECK_EN
      // Upstream WLAST early on beat 2 of a 4-beat burst
      apply_reset(1'b0);
      push_aw(6, 3);
      for (int b = 0; b < 4; b++) begin
         bus.S_AXI_WVALID = 1'b1;
         bus.S_AXI_WLAST  = (b == 1);
         @(negedge clk);
         chk($sformatf("t6_wid%0d", b), bus.M_AXI_WID, 6);
         chk($sformatf("t6_wlast%0d", b), bus.M_AXI_WLAST, 64'(b == 3));
         chk($sformatf("t6_err%0d", b), wlast_err, 64'(b >= 2));
         @(posedge clk); #1;
      end
      idle();
      chk_empty("t6");
      @(negedge clk);
      chk("t6_err_sticky", wlast_err, 1);
      apply_reset(1'b0);
      @(negedge clk);
      chk("t6_err_cleared", wlast_err, 0);
      @(posedge clk); #1;
      push_aw(2, 8'h12);
      @(negedge clk);
      chk("t6_awlen_err", wlast_err, 1);
      @(posedge clk); #1;
      for (int b = 0; b < 3; b++) w_beat("t6_hi", 2, b == 2);
      chk_empty("t6_hi");
`else
      // Upstream WLAST passes straight through and closes the burst
      apply_reset(1'b0);
      push_aw(2, 8'h12);
      w_beat("t6_pt", 2, 1'b0);
      w_beat("t6_pt", 2, 1'b1);
      chk_empty("t6_pt");
      chk("t6_err_tied", wlast_err, 0);
`endif

      // Randomized bursts against an in-order burst-list model
      apply_reset(1'b0);
      for (int i = 0; i < NB; i++) begin
         b_id[i]  = int'($urandom_range(0, 7));
         b_len[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                                : int'($urandom_range(0, 3));
      end
      begin
         int ai = 0;
         int wi = 0;
         int beat = 0;
         bit awh = 1'b0;
         bit wh = 1'b0;
         logic [DW-1:0] wd = '0;
         bit e_awv, e_awr, e_wv, e_wr;
         for (int cyc = 0; cyc < 8000 && wi < NB; cyc++) begin
            if (ai < NB) begin
               if (!awh) bus.S_AXI_AWVALID = ($urandom_range(0, 2) != 0);
               bus.S_AXI_AWID  = IDW'(b_id[ai]);
               bus.S_AXI_AWLEN = 8'(b_len[ai]);
            end else begin
               bus.S_AXI_AWVALID = 1'b0;
            end
            if (wi < NB) begin
               if (!wh) begin
                  bus.S_AXI_WVALID = ($urandom_range(0, 2) != 0);
                  wd = $urandom;
                  bus.S_AXI_WDATA = wd;
               end
               bus.S_AXI_WLAST = (beat == b_len[wi]);
            end else begin
               bus.S_AXI_WVALID = 1'b0;
            end
            bus.M_AXI_AWREADY = ($urandom_range(0, 3) != 0);
            bus.M_AXI_WREADY  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            e_awv = bus.S_AXI_AWVALID && (ai - wi < DEPTH);
            e_awr = bus.M_AXI_AWREADY && (ai - wi < DEPTH);
            e_wv  = bus.S_AXI_WVALID && (ai > wi);
            e_wr  = bus.M_AXI_WREADY && (ai > wi);
            chk("rnd_awvalid", bus.M_AXI_AWVALID, 64'(e_awv));
            chk("rnd_awready", bus.S_AXI_AWREADY, 64'(e_awr));
            chk("rnd_wvalid",  bus.M_AXI_WVALID,  64'(e_wv));
            chk("rnd_wready",  bus.S_AXI_WREADY,  64'(e_wr));
            if (e_awv) chk("rnd_awid", bus.M_AXI_AWID, 64'(b_id[ai]));
            if (e_wv) begin
               chk("rnd_wid",   bus.M_AXI_WID, 64'(b_id[wi]));
               chk("rnd_wlast", bus.M_AXI_WLAST, 64'(beat == b_len[wi]));
               chk("rnd_wdata", bus.M_AXI_WDATA, 64'(wd));
            end
            if (bus.S_AXI_AWVALID && e_awr) begin
               ai++;
               awh = 1'b0;
            end else begin
               awh = bus.S_AXI_AWVALID;
            end
            if (e_wv && bus.M_AXI_WREADY) begin
               wh = 1'b0;
               if (beat == b_len[wi]) begin
                  wi++;
                  beat = 0;
               end else begin
                  beat++;
               end
            end else begin
               wh = bus.S_AXI_WVALID;
            end
            @(posedge clk); #1;
         end
         chk("rnd_all_bursts_done", 64'(wi), 64'(NB));
         chk("rnd_no_err", wlast_err, 0);
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
